// File: rtl/stream_mux_arb_if.sv
// Handshake bundle for stream_mux_arb: N flattened producer lanes in, one registered consumer lane out.
// Optional STREAM_MUX_LOCK_EN adds din_last/dout_last for packet locking.
interface stream_mux_arb_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned NCH   = 4,
  parameter int unsigned SELW  = 2
);
  logic [NCH*WIDTH-1:0] din;
  logic [NCH-1:0]       din_valid;
  logic [NCH-1:0]       din_ready;
  logic [WIDTH-1:0]     dout;
  logic [SELW-1:0]      dout_ch;
  logic                 dout_valid;
  logic                 dout_ready;
`ifdef STREAM_MUX_LOCK_EN
  logic [NCH-1:0]       din_last;
  logic                 dout_last;

  modport master (
    output din, din_valid, din_last, dout_ready,
    input  din_ready, dout, dout_ch, dout_valid, dout_last
  );

  modport slave (
    input  din, din_valid, din_last, dout_ready,
    output din_ready, dout, dout_ch, dout_valid, dout_last
  );
`else
  modport master (
    output din, din_valid, dout_ready,
    input  din_ready, dout, dout_ch, dout_valid
  );

  modport slave (
    input  din, din_valid, dout_ready,
    output din_ready, dout, dout_ch, dout_valid
  );
`endif
endinterface

// File: rtl/stream_mux_arb.sv
// N-channel valid/ready stream mux with registered output; external-select or round-robin grant.
// Define STREAM_MUX_LOCK_EN to hold the grant on a channel until it sends a beat with din_last=1.
module stream_mux_arb #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned NCH   = 4,
  parameter int unsigned SELW  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mode,
  input  logic [SELW-1:0] sel,
  stream_mux_arb_if.slave stream
);

  logic [SELW-1:0]  rr_ptr;
  logic [SELW-1:0]  rr_grant;
  logic             rr_found;
  logic [SELW-1:0]  grant;
  logic             grant_vld;
  logic             load_ok;
  logic             xfer;
  logic [WIDTH-1:0] grant_data;

`ifdef STREAM_MUX_LOCK_EN
  typedef enum logic {ARB, LOCKED} lock_state_t;
  lock_state_t     lock_state;
  logic [SELW-1:0] lock_ch;
  logic            grant_last;
`endif

  function automatic int unsigned wrap(input int unsigned v);
    return (v >= NCH) ? v - NCH : v;
  endfunction

  assign load_ok = !stream.dout_valid || stream.dout_ready;

  // Outer loop walks priority order rr_ptr+1, rr_ptr+2, ...; first valid hit wins.
  always_comb begin
    rr_found = 1'b0;
    rr_grant = '0;
    for (int unsigned k = 1; k <= NCH; k++) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        if (!rr_found && stream.din_valid[i] && (wrap(32'(rr_ptr) + k) == i)) begin
          rr_found = 1'b1;
          rr_grant = SELW'(i);
        end
      end
    end
  end

  always_comb begin
    grant     = sel;
    grant_vld = (32'(sel) < NCH);
    if (mode) begin
      grant     = rr_grant;
      grant_vld = rr_found;
    end
`ifdef STREAM_MUX_LOCK_EN
    if (lock_state == LOCKED) begin
      grant     = lock_ch;
      grant_vld = 1'b1;
    end
`endif
  end

  always_comb begin
    stream.din_ready = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      stream.din_ready[i] = load_ok && grant_vld && (grant == SELW'(i));
    end
  end

  assign xfer = |(stream.din_valid & stream.din_ready);

  always_comb begin
    grant_data = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (grant == SELW'(i)) grant_data = stream.din[i*WIDTH +: WIDTH];
    end
  end

`ifdef STREAM_MUX_LOCK_EN
  always_comb begin
    grant_last = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (grant == SELW'(i)) grant_last = stream.din_last[i];
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      stream.dout       <= '0;
      stream.dout_ch    <= '0;
      stream.dout_valid <= 1'b0;
      rr_ptr            <= SELW'(NCH - 1);
`ifdef STREAM_MUX_LOCK_EN
      stream.dout_last  <= 1'b0;
      lock_state        <= ARB;
      lock_ch           <= '0;
`endif
    end else if (xfer) begin
      stream.dout       <= grant_data;
      stream.dout_ch    <= grant;
      stream.dout_valid <= 1'b1;
      if (mode) rr_ptr <= grant;
`ifdef STREAM_MUX_LOCK_EN
      stream.dout_last  <= grant_last;
      if (grant_last) begin
        lock_state <= ARB;
      end else begin
        lock_state <= LOCKED;
        lock_ch    <= grant;
      end
`endif
    end else if (stream.dout_ready) begin
      stream.dout_valid <= 1'b0;
    end
  end

  a_ready_onehot: assert property (@(posedge clk) $onehot0(stream.din_ready));

  a_hold_on_stall: assert property (@(posedge clk) disable iff (rst)
    stream.dout_valid && !stream.dout_ready |=>
      stream.dout_valid && $stable(stream.dout) && $stable(stream.dout_ch));

endmodule

// File: tb/tb_stream_mux_arb.sv
// Randomized self-checking bench for stream_mux_arb against a queue-free behavioural model,
// preceded by directed handshake, backpressure, select and reset scenarios.
module tb_stream_mux_arb;
  localparam int WIDTH = 4;
  localparam int NCH   = 4;
  localparam int SELW  = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            mode;
  logic [SELW-1:0] sel;

  stream_mux_arb_if #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW)) stream ();

  stream_mux_arb #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW)) dut (
    .clk    (clk),
    .rst    (rst),
    .mode   (mode),
    .sel    (sel),
    .stream (stream)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: the beat held in the output register and the last round-robin winner.
  bit m_valid;
  int m_data;
  int m_ch;
  int m_rr;

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = 0;
    m_ch    = 0;
    m_rr    = NCH - 1;
  endtask

  task automatic exp_grant(output int g, output bit gv);
    g  = 0;
    gv = 1'b0;
    if (!mode) begin
      g  = int'(sel);
      gv = (g < NCH);
    end else begin
      for (int k = 1; k <= NCH; k++) begin
        int c;
        c = (m_rr + k) % NCH;
        if (!gv && stream.din_valid[c]) begin
          g  = c;
          gv = 1'b1;
        end
      end
    end
  endtask

  // Called just after a negedge with inputs set; returns at the following negedge.
  task automatic cycle();
    int             g;
    bit             gv;
    logic [NCH-1:0] er;
    logic [NCH-1:0] dv;
    bit             xfer;
    #1;
    exp_grant(g, gv);
    er = '0;
    if ((!m_valid || stream.dout_ready) && gv) er[g] = 1'b1;
    check("din_ready", 32'(stream.din_ready), 32'(er));
    dv   = stream.din_valid;
    xfer = (er & dv) != '0;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else if (xfer) begin
      m_valid = 1'b1;
      m_data  = int'(stream.din[g*WIDTH +: WIDTH]);
      m_ch    = g;
      if (mode) m_rr = g;
    end else if (stream.dout_ready) begin
      m_valid = 1'b0;
    end
    @(negedge clk);
    check("dout_valid", 32'(stream.dout_valid), 32'(m_valid));
    check("dout", 32'(stream.dout), 32'(m_data));
    check("dout_ch", 32'(stream.dout_ch), 32'(m_ch));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  logic [WIDTH-1:0] held;
  logic [SELW-1:0]  held_ch;

  initial begin
    rst               = 1'b1;
    mode              = 1'b0;
    sel               = '0;
    stream.din        = '0;
    stream.din_valid  = '0;
    stream.dout_ready = 1'b0;
`ifdef STREAM_MUX_LOCK_EN
    stream.din_last   = '1;
`endif
    repeat (2) @(negedge clk);
    model_reset();
    check("rst_dout", 32'(stream.dout), 32'd0);
    check("rst_dout_ch", 32'(stream.dout_ch), 32'd0);
    check("rst_dout_valid", 32'(stream.dout_valid), 32'd0);
    rst = 1'b0;

    // Mode 0, sel=2, only ch2 valid.
    sel               = 2'd2;
    stream.din        = 16'h0A00;
    stream.din_valid  = 4'b0100;
    stream.dout_ready = 1'b1;
    #1 check("t1_ready", 32'(stream.din_ready), 32'h4);
    cycle();
    check("t1_dout", 32'(stream.dout), 32'hA);
    check("t1_ch", 32'(stream.dout_ch), 32'd2);
    check("t1_valid", 32'(stream.dout_valid), 32'd1);

    // Round-robin with every channel valid: 0,1,2,3,0 back to back.
    do_reset();
    mode              = 1'b1;
    stream.din_valid  = 4'hF;
    stream.din        = 16'h7C3E;
    stream.dout_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("t2_ch", 32'(stream.dout_ch), 32'(i % NCH));
      check("t2_valid", 32'(stream.dout_valid), 32'd1);
    end

    // Backpressure for three cycles, then drain.
    held              = stream.dout;
    held_ch           = stream.dout_ch;
    stream.dout_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      stream.din = 16'(i * 16'h1111);
      #1 check("t3_ready", 32'(stream.din_ready), 32'd0);
      cycle();
      check("t3_hold", 32'(stream.dout), 32'(held));
      check("t3_hold_ch", 32'(stream.dout_ch), 32'(held_ch));
      check("t3_valid", 32'(stream.dout_valid), 32'd1);
    end
    stream.dout_ready = 1'b1;
    stream.din_valid  = '0;
    cycle();
    check("t3_drain", 32'(stream.dout_valid), 32'd0);

    // Mode 0 with sel on an idle channel: no fallback to the valid one.
    mode             = 1'b0;
    sel              = 2'd3;
    stream.din       = 16'h00B0;
    stream.din_valid = 4'b0010;
    for (int i = 0; i < 2; i++) begin
      #1 check("t4_ready1", 32'(stream.din_ready[1]), 32'd0);
      cycle();
      check("t4_idle", 32'(stream.dout_valid), 32'd0);
    end
    sel = 2'd1;
    cycle();
    check("t4_ch", 32'(stream.dout_ch), 32'd1);
    check("t4_dout", 32'(stream.dout), 32'hB);

    // Reset discards a held beat and restores ch0 priority.
    do_reset();
    mode              = 1'b1;
    stream.din        = 16'h0500;
    stream.din_valid  = 4'b0100;
    stream.dout_ready = 1'b0;
    cycle();
    check("t5_pre_ch", 32'(stream.dout_ch), 32'd2);
    check("t5_pre_valid", 32'(stream.dout_valid), 32'd1);
    rst              = 1'b1;
    stream.din_valid = 4'hF;
    cycle();
    check("t5_valid", 32'(stream.dout_valid), 32'd0);
    check("t5_dout", 32'(stream.dout), 32'd0);
    rst               = 1'b0;
    stream.dout_ready = 1'b1;
    cycle();
    check("t5_ch", 32'(stream.dout_ch), 32'd0);

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      mode              = 1'($urandom_range(0, 1));
      sel               = SELW'($urandom);
      stream.din        = 16'($urandom);
      stream.din_valid  = 4'($urandom);
      stream.dout_ready = ($urandom_range(0, 3) != 0);
      rst               = ($urandom_range(0, 49) == 0);
      cycle();
    end
    rst = 1'b0;

`ifdef STREAM_MUX_LOCK_EN
    // Lock: ch1 sends last=0,0,1 while ch0/ch2 stay valid.
    begin
      logic [NCH-1:0] last_tab [5];
      int             ch_tab   [5];
      bit             lst_tab  [5];
      last_tab = '{4'b1111, 4'b1101, 4'b1101, 4'b1111, 4'b1111};
      ch_tab   = '{0, 1, 1, 1, 2};
      lst_tab  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      do_reset();
      mode              = 1'b1;
      stream.din_valid  = 4'b0111;
      stream.din        = 16'h0321;
      stream.dout_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
        stream.din_last = last_tab[i];
        @(posedge clk);
        @(negedge clk);
        check("t6_ch", 32'(stream.dout_ch), 32'(ch_tab[i]));
        check("t6_last", 32'(stream.dout_last), 32'(lst_tab[i]));
      end
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
